abm_load_sched: RTL

Sequences ABM loads from host RAM into the two ABM loader engines over the shared PCIe read path. It sits between the AXI control-register block, which supplies the load request mask, its write strobe and the 64-bit source address, and the two loader engines, which take a start pulse and address and report idle. Loads run strictly one engine at a time. Requests arriving mid-batch are queued for the next batch, and a hung engine is detected by timeout.

---
 rtl/abm_load_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/abm_load_sched.sv
// rtl/abm_load_sched.sv - one-at-a-time ABM load sequencer across the two loader engines
module abm_load_sched #(
  parameter logic [63:0] ABM_BYTES      = 64'h0000_0000_0040_0000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  load_req,
  input  logic        load_wstrobe,
  input  logic [63:0] pci_src_addr,
  input  logic        idle_0,
  input  logic        idle_1,
  output logic        start_0,
  output logic        start_1,
  output logic [63:0] addr_0,
  output logic [63:0] addr_1,
  output logic [1:0]  busy,
  output logic        done,
  output logic        timeout_err,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_READY, S_ACK, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  pend_mask, act_mask;
  logic [63:0] pend_addr, base;
  logic        cur;
  logic [31:0] timer;

  logic        cur_idle, timer_hit, in_flight, sel_n, strobe_ok;
  logic        take, sel, launch, tmr_clr, tmo;
  logic [1:0]  pend_eff;

  assign cur_idle  = cur ? idle_1 : idle_0;
  assign timer_hit = (timer == TIMEOUT_CYCLES - 32'd1);
  assign in_flight = (state == S_READY) || (state == S_ACK) || (state == S_RUN);
  assign sel_n     = ~act_mask[0];
  assign strobe_ok = load_wstrobe && (load_req != 2'b00);
  // A strobe in the IDLE hand-off cycle lands in the freshly emptied queue.
  assign pend_eff  = take ? 2'b00 : pend_mask;
  assign busy      = pend_mask | act_mask | (in_flight ? (cur ? 2'b10 : 2'b01) : 2'b00);

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    sel       = 1'b0;
    launch    = 1'b0;
    tmr_clr   = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_mask != 2'b00) begin
          take      = 1'b1;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        sel       = 1'b1;
        tmr_clr   = 1'b1;
        state_nxt = S_READY;
      end
      S_READY: begin
        if (cur_idle) begin
          launch    = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = S_ACK;
        end else if (timer_hit) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_ACK: begin
        if (!cur_idle) begin
          tmr_clr   = 1'b1;
          state_nxt = S_RUN;
        end else if (timer_hit) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (cur_idle) begin
          state_nxt = (act_mask != 2'b00) ? S_SELECT : S_DONE;
        end else if (timer_hit) begin
          tmo       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pend_mask   <= 2'b00;
      pend_addr   <= 64'd0;
      act_mask    <= 2'b00;
      base        <= 64'd0;
      cur         <= 1'b0;
      timer       <= 32'd0;
      start_0     <= 1'b0;
      start_1     <= 1'b0;
      addr_0      <= 64'd0;
      addr_1      <= 64'd0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_0 <= launch && !cur;
      start_1 <= launch && cur;
      done    <= (state == S_DONE);

      if (tmr_clr) begin
        timer <= 32'd0;
      end else if (in_flight) begin
        timer <= timer + 32'd1;
      end

      if (take) begin
        act_mask <= pend_mask;
        base     <= pend_addr;
      end else if (sel) begin
        act_mask <= act_mask & ~(sel_n ? 2'b10 : 2'b01);
        cur      <= sel_n;
        if (sel_n) begin
          addr_1 <= base + ABM_BYTES;
        end else begin
          addr_0 <= base;
        end
      end else if (tmo) begin
        act_mask <= 2'b00;
      end

      if (strobe_ok) begin
        pend_mask <= pend_eff | load_req;
        pend_addr <= pci_src_addr;
        overrun   <= (pend_eff != 2'b00);
      end else begin
        pend_mask <= pend_eff;
      end

      // A timeout in the same cycle as a strobe is a fresh event and wins.
      if (tmo) begin
        timeout_err <= 1'b1;
      end else if (strobe_ok) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
